// File: rtl/iic_init_seq.sv
// rtl/iic_init_seq.sv - table-driven IIC register-write sequencer in front of iic_rw
module iic_init_seq #(
    parameter int ADDRWIDTH = 16,
    parameter int NUMWIDTH  = 2,
    parameter int TABWIDTH  = 8,
    parameter int GAPCYCLES = 1000,
    parameter int MAXRETRY  = 3
) (
    input  logic                   I_clk,
    input  logic                   I_rstn,
    input  logic                   I_go,
    input  logic [TABWIDTH-1:0]    I_tablen,
    output logic                   O_busy,
    output logic                   O_done,
    output logic                   O_fail,
    output logic [TABWIDTH-1:0]    O_failidx,
    output logic [TABWIDTH-1:0]    O_tabaddr,
    input  logic [14+ADDRWIDTH:0]  I_tabdata,
    output logic [6:0]             O_device,
    output logic                   O_rw,
    output logic [ADDRWIDTH-1:0]   O_addr,
    output logic [NUMWIDTH-1:0]    O_num,
    output logic                   O_start,
    output logic [7:0]             O_databyte,
    input  logic                   I_busy,
    input  logic                   I_error
);

    localparam int GW = $clog2(GAPCYCLES + 1);
    localparam int RW = (MAXRETRY > 0) ? $clog2(MAXRETRY + 1) : 1;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_LOAD, S_START, S_WAITBUSY, S_RUN, S_CHECK, S_GAP, S_DONE
    } state_t;

    state_t              state, state_n;
    logic [TABWIDTH-1:0] idx, tablen_r;
    logic [RW-1:0]       retry;
    logic [GW-1:0]       gcnt;
    logic [1:0]          wcnt;
    logic                err;
    logic                gap_retry;

    always_ff @(posedge I_clk or negedge I_rstn) begin
        if (!I_rstn) state <= S_IDLE;
        else         state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:     if (I_go) state_n = (I_tablen == '0) ? S_DONE : S_FETCH;
            S_FETCH:    state_n = S_LOAD;
            S_LOAD:     state_n = S_START;
            S_START:    state_n = S_WAITBUSY;
            S_WAITBUSY: begin
                if (I_busy)             state_n = S_RUN;
                else if (wcnt == 2'd3)  state_n = S_CHECK;
            end
            S_RUN:      if (!I_busy) state_n = S_CHECK;
            S_CHECK: begin
                if (!err || retry < RW'(MAXRETRY)) state_n = S_GAP;
                else                               state_n = S_DONE;
            end
            // idx was already advanced in CHECK, so this compare sees the next entry
            S_GAP: begin
                if (gcnt == GW'(GAPCYCLES - 1)) begin
                    if (gap_retry)            state_n = S_START;
                    else if (idx < tablen_r)  state_n = S_FETCH;
                    else                      state_n = S_DONE;
                end
            end
            S_DONE:     state_n = S_IDLE;
            default:    state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge I_clk or negedge I_rstn) begin
        if (!I_rstn) begin
            idx        <= '0;
            tablen_r   <= '0;
            retry      <= '0;
            gcnt       <= '0;
            wcnt       <= '0;
            err        <= 1'b0;
            gap_retry  <= 1'b0;
            O_fail     <= 1'b0;
            O_failidx  <= '0;
            O_device   <= '0;
            O_addr     <= '0;
            O_databyte <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (I_go) begin
                        tablen_r <= I_tablen;
                        idx      <= '0;
                        retry    <= '0;
                        O_fail   <= 1'b0;
                    end
                end
                S_LOAD: begin
                    O_device   <= I_tabdata[14+ADDRWIDTH -: 7];
                    O_addr     <= I_tabdata[ADDRWIDTH+7:8];
                    O_databyte <= I_tabdata[7:0];
                end
                S_START:    wcnt <= '0;
                S_WAITBUSY: begin
                    wcnt <= wcnt + 2'd1;
                    if (!I_busy && wcnt == 2'd3) err <= 1'b1;
                end
                S_RUN:      if (!I_busy) err <= I_error;
                S_CHECK: begin
                    gcnt <= '0;
                    if (!err) begin
                        retry     <= '0;
                        idx       <= idx + 1'b1;
                        gap_retry <= 1'b0;
                    end else if (retry < RW'(MAXRETRY)) begin
                        retry     <= retry + 1'b1;
                        gap_retry <= 1'b1;
                    end else begin
                        O_fail    <= 1'b1;
                        O_failidx <= idx;
                    end
                end
                S_GAP:      gcnt <= gcnt + 1'b1;
                default: ;
            endcase
        end
    end

    assign O_busy    = (state != S_IDLE);
    assign O_done    = (state == S_DONE);
    assign O_start   = (state == S_START);
    assign O_tabaddr = idx;
    assign O_rw      = 1'b0;
    assign O_num     = NUMWIDTH'(1);

endmodule

// File: tb/tb_iic_init_seq.sv
// tb/tb_iic_init_seq.sv - directed self-checking bench for iic_init_seq with an iic_rw responder
module tb_iic_init_seq;

    localparam int AW  = 16;
    localparam int NW  = 2;
    localparam int TW  = 8;
    localparam int GAP = 10;
    localparam int MR  = 3;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic            go = 1'b0;
    logic [TW-1:0]   tablen = '0;
    logic            o_busy, o_done, o_fail, o_rw, o_start;
    logic [TW-1:0]   o_failidx, tabaddr;
    logic [14+AW:0]  tabdata;
    logic [6:0]      o_device;
    logic [AW-1:0]   o_addr;
    logic [NW-1:0]   o_num;
    logic [7:0]      o_databyte;
    logic            ibusy, ierr;

    iic_init_seq #(.ADDRWIDTH(AW), .NUMWIDTH(NW), .TABWIDTH(TW), .GAPCYCLES(GAP), .MAXRETRY(MR)) dut (
        .I_clk(clk), .I_rstn(rstn), .I_go(go), .I_tablen(tablen),
        .O_busy(o_busy), .O_done(o_done), .O_fail(o_fail), .O_failidx(o_failidx),
        .O_tabaddr(tabaddr), .I_tabdata(tabdata), .O_device(o_device), .O_rw(o_rw),
        .O_addr(o_addr), .O_num(o_num), .O_start(o_start), .O_databyte(o_databyte),
        .I_busy(ibusy), .I_error(ierr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [14+AW:0] rom [0:255];
    always @(posedge clk) tabdata <= rom[tabaddr];

    logic [AW-1:0] exp_addr [0:2] = '{16'h0100, 16'h0101, 16'h3008};
    logic [7:0]    exp_data [0:2] = '{8'hA5, 8'h5A, 8'h82};

    int total = 0;
    int bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // responder: models iic_rw busy/error handshake and logs every start
    int         n_start = 0;
    int         run_base = 0;
    int         last_fall = -1000;
    int         nack_cfg [0:3] = '{0, 0, 0, 0};
    int         no_busy_idx = -1;
    int         log_idx  [0:127];
    int         log_cyc  [0:127];
    int         log_gap  [0:127];
    logic [AW-1:0] log_addr [0:127];
    logic [7:0]    log_data [0:127];
    logic [6:0]    log_dev  [0:127];

    initial begin
        ibusy = 1'b0;
        ierr  = 1'b0;
        forever begin
            @(negedge clk);
            if (o_start) begin
                int e;
                int tries;
                e = int'(tabaddr);
                tries = 1;
                for (int k = run_base; k < n_start; k++) if (log_idx[k] == e) tries++;
                log_idx[n_start]  = e;
                log_cyc[n_start]  = cyc;
                log_gap[n_start]  = cyc - last_fall;
                log_addr[n_start] = o_addr;
                log_data[n_start] = o_databyte;
                log_dev[n_start]  = o_device;
                n_start++;
                if (e != no_busy_idx) begin
                    @(negedge clk);
                    ibusy = 1'b1;
                    ierr  = 1'b0;
                    repeat (4) @(negedge clk);
                    ierr  = (e < 4 && tries <= nack_cfg[e]);
                    ibusy = 1'b0;
                    last_fall = cyc;
                end
            end
        end
    end

    int done_total = 0;
    int busy_total = 0;
    always @(negedge clk) begin
        if (o_done) done_total <= done_total + 1;
        if (o_busy) busy_total <= busy_total + 1;
    end

    int go_cyc = 0;

    task automatic run_seq(input int len, input bit inject,
                           output int base, output int dones, output int busyc);
        int d0, b0;
        bit injd, to;
        base = n_start;
        run_base = n_start;
        d0 = done_total;
        b0 = busy_total;
        injd = 1'b0;
        to = 1'b1;
        @(negedge clk);
        tablen = TW'(len);
        go = 1'b1;
        go_cyc = cyc;
        @(negedge clk);
        go = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            #1;
            if (done_total != d0) begin
                to = 1'b0;
                break;
            end
            @(negedge clk);
            go = inject && !injd && ibusy;
            if (go) injd = 1'b1;
        end
        go = 1'b0;
        check("timeout", 32'(to), 32'd0);
        repeat (15) @(negedge clk);
        dones = done_total - d0;
        busyc = busy_total - b0;
    endtask

    int base, dones, busyc;
    int seq2 [0:3] = '{0, 1, 1, 2};
    int seq3 [0:5] = '{0, 1, 2, 2, 2, 2};
    int seq6 [0:4] = '{0, 1, 1, 1, 1};

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = '0;
        for (int i = 0; i < 3; i++) rom[i] = {7'h3C, exp_addr[i], exp_data[i]};

        repeat (3) @(negedge clk);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_done", 32'(o_done), 32'd0);
        check("rst_fail", 32'(o_fail), 32'd0);
        check("rst_start", 32'(o_start), 32'd0);
        check("rst_failidx", 32'(o_failidx), 32'd0);
        check("rst_dev", 32'(o_device), 32'd0);
        check("rst_addr", 32'(o_addr), 32'd0);
        check("rst_data", 32'(o_databyte), 32'd0);
        check("rst_tabaddr", 32'(tabaddr), 32'd0);
        check("rw_const", 32'(o_rw), 32'd0);
        check("num_const", 32'(o_num), 32'd1);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // all ACK
        run_seq(3, 1'b0, base, dones, busyc);
        check("t1_starts", 32'(n_start - base), 32'd3);
        check("t1_latency", 32'(log_cyc[base] - go_cyc), 32'd3);
        for (int k = 0; k < 3; k++) begin
            check("t1_addr", 32'(log_addr[base+k]), 32'(exp_addr[k]));
            check("t1_data", 32'(log_data[base+k]), 32'(exp_data[k]));
            check("t1_dev", 32'(log_dev[base+k]), 32'h3C);
            if (k > 0) check("t1_gap", 32'(log_gap[base+k] >= GAP), 32'd1);
        end
        check("t1_dones", 32'(dones), 32'd1);
        check("t1_fail", 32'(o_fail), 32'd0);

        // entry 1 NACKs once
        nack_cfg[1] = 1;
        run_seq(3, 1'b0, base, dones, busyc);
        check("t2_starts", 32'(n_start - base), 32'd4);
        for (int k = 0; k < 4; k++) begin
            check("t2_addr", 32'(log_addr[base+k]), 32'(exp_addr[seq2[k]]));
            check("t2_data", 32'(log_data[base+k]), 32'(exp_data[seq2[k]]));
        end
        check("t2_retry_gap", 32'(log_gap[base+2] >= GAP), 32'd1);
        check("t2_dones", 32'(dones), 32'd1);
        check("t2_fail", 32'(o_fail), 32'd0);

        // entry 2 always NACKs
        nack_cfg[1] = 0;
        nack_cfg[2] = 99;
        run_seq(3, 1'b0, base, dones, busyc);
        check("t3_starts", 32'(n_start - base), 32'd6);
        for (int k = 0; k < 6; k++) check("t3_idx", 32'(log_idx[base+k]), 32'(seq3[k]));
        check("t3_dones", 32'(dones), 32'd1);
        check("t3_fail", 32'(o_fail), 32'd1);
        check("t3_failidx", 32'(o_failidx), 32'd2);

        // go during RUN ignored; new go clears fail and restarts at entry 0
        nack_cfg[2] = 0;
        run_seq(3, 1'b1, base, dones, busyc);
        check("t5_starts", 32'(n_start - base), 32'd3);
        check("t5_first_addr", 32'(log_addr[base]), 32'h0100);
        check("t5_last_addr", 32'(log_addr[base+2]), 32'h3008);
        check("t5_dones", 32'(dones), 32'd1);
        check("t5_fail", 32'(o_fail), 32'd0);

        // empty table
        run_seq(0, 1'b0, base, dones, busyc);
        check("t4_starts", 32'(n_start - base), 32'd0);
        check("t4_dones", 32'(dones), 32'd1);
        check("t4_busy_cycles", 32'(busyc), 32'd1);

        // iic_rw never goes busy on entry 1
        no_busy_idx = 1;
        run_seq(3, 1'b0, base, dones, busyc);
        check("t6_starts", 32'(n_start - base), 32'd5);
        for (int k = 0; k < 5; k++) check("t6_idx", 32'(log_idx[base+k]), 32'(seq6[k]));
        check("t6_fail", 32'(o_fail), 32'd1);
        check("t6_failidx", 32'(o_failidx), 32'd1);
        no_busy_idx = -1;

        // async reset in the middle of a transfer
        begin
            bit saw;
            saw = 1'b0;
            run_base = n_start;
            @(negedge clk);
            tablen = TW'(3);
            go = 1'b1;
            @(negedge clk);
            go = 1'b0;
            for (int i = 0; i < 50; i++) begin
                if (ibusy) begin
                    saw = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            check("t7_saw_run", 32'(saw), 32'd1);
            #2 rstn = 1'b0;
            #1;
            check("t7_busy", 32'(o_busy), 32'd0);
            check("t7_start", 32'(o_start), 32'd0);
            check("t7_fail", 32'(o_fail), 32'd0);
            check("t7_failidx", 32'(o_failidx), 32'd0);
            check("t7_dev", 32'(o_device), 32'd0);
            check("t7_addr", 32'(o_addr), 32'd0);
            check("t7_data", 32'(o_databyte), 32'd0);
            check("t7_tabaddr", 32'(tabaddr), 32'd0);
            repeat (10) @(negedge clk);
            rstn = 1'b1;
            repeat (2) @(negedge clk);
        end

        run_seq(3, 1'b0, base, dones, busyc);
        check("t8_starts", 32'(n_start - base), 32'd3);
        check("t8_dones", 32'(dones), 32'd1);
        check("t8_fail", 32'(o_fail), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
